// File: rtl/pwm_multi.sv
// Multi-channel edge-aligned PWM with shared prescaler/period counter and shadowed duty/period.
// Optional POLARITY register is built only when PWM_POLARITY_EN is defined.
module pwm_multi #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CW    = 8,
    parameter int unsigned PRE_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             reg_we_i,
    input  logic [3:0]       reg_addr_i,
    input  logic [15:0]      reg_wdata_i,
    output logic [15:0]      reg_rdata_o,
    output logic [NCH-1:0]   cio_pwm_o,
    output logic [NCH-1:0]   cio_pwm_en_o,
    output logic             wrap_o
);

    localparam int unsigned AW        = 4;
    localparam int unsigned DW        = 16;
    localparam int unsigned DUTY_BASE = 4;

    localparam logic [AW-1:0] ADDR_CTRL   = AW'(0);
    localparam logic [AW-1:0] ADDR_PRE    = AW'(1);
    localparam logic [AW-1:0] ADDR_PERIOD = AW'(2);
    localparam logic [AW-1:0] ADDR_POL    = AW'(3);

    logic [NCH-1:0]   ctrl_q;
    logic [PRE_W-1:0] prescale_q;
    logic [CW-1:0]    period_sh_q;
    logic [CW-1:0]    period_act_q;
    logic [CW-1:0]    duty_sh_q  [NCH];
    logic [CW-1:0]    duty_act_q [NCH];
    logic [PRE_W-1:0] pre_q;
    logic [CW-1:0]    cnt_q;
    logic [NCH-1:0]   pwm_q;
    logic [NCH-1:0]   pol;

    logic             wr_ctrl, wr_pre, wr_period, wr_pol;
    logic [NCH-1:0]   wr_duty;
    logic [CW-1:0]    period_nxt;
    logic [CW-1:0]    duty_nxt [NCH];
    logic [NCH-1:0]   raw;
    logic             run, tick, wrap, load;
    logic             unused_wdata;

    assign unused_wdata = ^reg_wdata_i;

    // Write decode and next shadow values (a write is visible to a same-cycle active load)
    always_comb begin
        wr_ctrl   = reg_we_i && (reg_addr_i == ADDR_CTRL);
        wr_pre    = reg_we_i && (reg_addr_i == ADDR_PRE);
        wr_period = reg_we_i && (reg_addr_i == ADDR_PERIOD);
        wr_pol    = reg_we_i && (reg_addr_i == ADDR_POL);
        wr_duty   = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            wr_duty[i] = reg_we_i && (reg_addr_i == AW'(DUTY_BASE + 32'(i)));
        end
        period_nxt = wr_period ? reg_wdata_i[CW-1:0] : period_sh_q;
        for (int i = 0; i < int'(NCH); i++) begin
            duty_nxt[i] = wr_duty[i] ? reg_wdata_i[CW-1:0] : duty_sh_q[i];
        end
    end

    assign run  = |ctrl_q;
    assign tick = run && (pre_q == prescale_q);
    assign wrap = tick && (cnt_q == period_act_q);
    assign load = !run || wrap;

    // Configuration registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q      <= '0;
            prescale_q  <= '0;
            period_sh_q <= '1;
        end else begin
            if (wr_ctrl)   ctrl_q      <= reg_wdata_i[NCH-1:0];
            if (wr_pre)    prescale_q  <= reg_wdata_i[PRE_W-1:0];
            if (wr_period) period_sh_q <= reg_wdata_i[CW-1:0];
        end
    end

`ifdef PWM_POLARITY_EN
    logic [NCH-1:0] pol_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pol_q <= '0;
        end else if (wr_pol) begin
            pol_q <= reg_wdata_i[NCH-1:0];
        end
    end

    assign pol = pol_q;
`else
    logic unused_wr_pol;

    assign unused_wr_pol = wr_pol;
    assign pol           = '0;
`endif

    // Duty shadows and active copies
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NCH); i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
            period_act_q <= '1;
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                duty_sh_q[i] <= duty_nxt[i];
                if (load) duty_act_q[i] <= duty_nxt[i];
            end
            if (load) period_act_q <= period_nxt;
        end
    end

    // Prescaler; an out-of-range pre (PRESCALE lowered below it) restarts without ticking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q <= '0;
        end else if (!run || (pre_q >= prescale_q)) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Period counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!run || wrap) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            raw[i] = cnt_q < duty_act_q[i];
        end
    end

    // Registered compare output; disabled channels forced low regardless of polarity
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= ctrl_q & (raw ^ pol);
        end
    end

    // Combinational register read
    always_comb begin
        reg_rdata_o = '0;
        case (reg_addr_i)
            ADDR_CTRL:   reg_rdata_o = DW'(ctrl_q);
            ADDR_PRE:    reg_rdata_o = DW'(prescale_q);
            ADDR_PERIOD: reg_rdata_o = DW'(period_sh_q);
            ADDR_POL:    reg_rdata_o = DW'(pol);
            default: begin
                for (int i = 0; i < int'(NCH); i++) begin
                    if (reg_addr_i == AW'(DUTY_BASE + 32'(i))) begin
                        reg_rdata_o = DW'(duty_sh_q[i]);
                    end
                end
            end
        endcase
    end

    assign cio_pwm_o    = pwm_q;
    assign cio_pwm_en_o = ctrl_q;
    assign wrap_o       = wrap;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: register table, directed period/duty sequences,
// async reset, and randomized writes against a behavioural model.
module tb_pwm_multi;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned PRE_W = 8;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             reg_we_i;
    logic [3:0]       reg_addr_i;
    logic [15:0]      reg_wdata_i;
    logic [15:0]      reg_rdata_o;
    logic [NCH-1:0]   cio_pwm_o;
    logic [NCH-1:0]   cio_pwm_en_o;
    logic             wrap_o;

    always #5 clk = ~clk;

    pwm_multi #(.NCH(NCH), .CW(CW), .PRE_W(PRE_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .reg_we_i     (reg_we_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_rdata_o  (reg_rdata_o),
        .cio_pwm_o    (cio_pwm_o),
        .cio_pwm_en_o (cio_pwm_en_o),
        .wrap_o       (wrap_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference state
    logic [NCH-1:0]   m_ctrl, m_pol, m_pwm;
    logic [PRE_W-1:0] m_prescale, m_pre;
    logic [CW-1:0]    m_period_sh, m_period_act, m_cnt;
    logic [CW-1:0]    m_duty_sh  [NCH];
    logic [CW-1:0]    m_duty_act [NCH];

    task automatic model_reset();
        m_ctrl = '0; m_pol = '0; m_pwm = '0;
        m_prescale = '0; m_pre = '0; m_cnt = '0;
        m_period_sh = '1; m_period_act = '1;
        for (int i = 0; i < int'(NCH); i++) begin
            m_duty_sh[i] = '0;
            m_duty_act[i] = '0;
        end
    endtask

    function automatic logic m_wrap();
        return (|m_ctrl) && (m_pre == m_prescale) && (m_cnt == m_period_act);
    endfunction

    function automatic logic [15:0] m_read(input logic [3:0] a);
        case (a)
            4'd0: return 16'(m_ctrl);
            4'd1: return 16'(m_prescale);
            4'd2: return 16'(m_period_sh);
            4'd3: return 16'(m_pol);
            default: begin
                if (int'(a) - 4 < int'(NCH)) return 16'(m_duty_sh[int'(a) - 4]);
                return 16'h0;
            end
        endcase
    endfunction

    // One clock of the reference: counters from old state, then register writes, then shadow load
    task automatic model_edge(input logic we, input logic [3:0] a, input logic [15:0] wd);
        logic run, tick, wr;
        run  = |m_ctrl;
        tick = run && (m_pre == m_prescale);
        wr   = tick && (m_cnt == m_period_act);
        for (int i = 0; i < int'(NCH); i++) begin
            m_pwm[i] = m_ctrl[i] & ((m_cnt < m_duty_act[i]) ^ m_pol[i]);
        end
        if (!run) begin
            m_pre = '0;
            m_cnt = '0;
        end else begin
            m_pre = (m_pre < m_prescale) ? m_pre + PRE_W'(1) : '0;
            if (tick) m_cnt = wr ? '0 : m_cnt + CW'(1);
        end
        if (we) begin
            case (a)
                4'd0: m_ctrl = wd[NCH-1:0];
                4'd1: m_prescale = wd[PRE_W-1:0];
                4'd2: m_period_sh = wd[CW-1:0];
                4'd3: begin
`ifdef PWM_POLARITY_EN
                    m_pol = wd[NCH-1:0];
`endif
                end
                default: if (int'(a) - 4 < int'(NCH)) m_duty_sh[int'(a) - 4] = wd[CW-1:0];
            endcase
        end
        if (!run || wr) begin
            m_period_act = m_period_sh;
            for (int i = 0; i < int'(NCH); i++) m_duty_act[i] = m_duty_sh[i];
        end
    endtask

    task automatic cyc(input logic we, input logic [3:0] a, input logic [15:0] wd);
        @(negedge clk);
        reg_we_i    = we;
        reg_addr_i  = a;
        reg_wdata_i = wd;
        @(posedge clk);
        model_edge(we, a, wd);
        #1;
        chk("outputs", int'({cio_pwm_o, cio_pwm_en_o, wrap_o}), int'({m_pwm, m_ctrl, m_wrap()}));
        chk("rdata", int'(reg_rdata_o), int'(m_read(a)));
    endtask

    task automatic do_reset();
        reg_we_i = 1'b0;
        rst_ni   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic window(input int n, output int h0, output int h1, output int h2,
                          output int h3, output int w, output int run0);
        int cur;
        h0 = 0; h1 = 0; h2 = 0; h3 = 0; w = 0; run0 = 0; cur = 0;
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 4'd2, 16'h0);
            h0 += int'(cio_pwm_o[0]);
            h1 += int'(cio_pwm_o[1]);
            h2 += int'(cio_pwm_o[2]);
            h3 += int'(cio_pwm_o[3]);
            w  += int'(wrap_o);
            cur = cio_pwm_o[0] ? cur + 1 : 0;
            if (cur > run0) run0 = cur;
        end
    endtask

    task automatic wait_wrap();
        int k = 0;
        do begin
            cyc(1'b0, 4'd2, 16'h0);
            k++;
        end while (!wrap_o && k < 200);
        chk("wrap_seen", int'(wrap_o), 1);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [9];

    initial begin
        int h0, h1, h2, h3, w, r0, h, k;
        logic we;
        logic [3:0] a;
        logic [15:0] wd;

        vecs[0] = '{4'd0,  16'h00A5, 16'h0005};
        vecs[1] = '{4'd1,  16'h1234, 16'h0034};
        vecs[2] = '{4'd2,  16'hABCD, 16'h00CD};
`ifdef PWM_POLARITY_EN
        vecs[3] = '{4'd3,  16'hFFFA, 16'h000A};
`else
        vecs[3] = '{4'd3,  16'hFFFA, 16'h0000};
`endif
        vecs[4] = '{4'd4,  16'h0102, 16'h0002};
        vecs[5] = '{4'd7,  16'hFF80, 16'h0080};
        vecs[6] = '{4'd8,  16'h0055, 16'h0000};
        vecs[7] = '{4'd15, 16'hFFFF, 16'h0000};
        vecs[8] = '{4'd0,  16'h0000, 16'h0000};

        reg_we_i = 1'b0; reg_addr_i = 4'd2; reg_wdata_i = '0;
        do_reset();

        // Reset state
        cyc(1'b0, 4'd2, 16'h0);
        chk("reset_pwm", int'(cio_pwm_o), 0);
        chk("reset_en", int'(cio_pwm_en_o), 0);
        chk("reset_wrap", int'(wrap_o), 0);
        chk("reset_period", int'(reg_rdata_o), 255);

        // Register write/readback table
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("reg_rb[%0d]", i), int'(reg_rdata_o), int'(vecs[i].exp));
        end

        // Basic duty
        do_reset();
        cyc(1'b1, 4'd1, 16'd0); cyc(1'b1, 4'd2, 16'd9); cyc(1'b1, 4'd4, 16'd3); cyc(1'b1, 4'd0, 16'd1);
        repeat (3) cyc(1'b0, 4'd2, 16'h0);
        window(30, h0, h1, h2, h3, w, r0);
        chk("basic_high", h0, 9);
        chk("basic_wraps", w, 3);
        chk("basic_run", r0, 3);
        chk("basic_en", int'(cio_pwm_en_o), 1);

        // Shadow update mid-period
        wait_wrap();
        h = 0;
        for (int j = 1; j <= 10; j++) begin
            if (j == 5) cyc(1'b1, 4'd4, 16'd7);
            else        cyc(1'b0, 4'd2, 16'h0);
            h += int'(cio_pwm_o[0]);
        end
        chk("shadow_old", h, 3);
        chk("shadow_wrap", int'(wrap_o), 1);
        window(10, h0, h1, h2, h3, w, r0);
        chk("shadow_new", h0, 7);

        // Boundaries
        cyc(1'b1, 4'd0, 16'd0); cyc(1'b1, 4'd5, 16'd0); cyc(1'b1, 4'd6, 16'd10);
        cyc(1'b1, 4'd2, 16'd9); cyc(1'b1, 4'd0, 16'd6);
        repeat (3) cyc(1'b0, 4'd2, 16'h0);
        window(25, h0, h1, h2, h3, w, r0);
        chk("bnd_ch1_zero", h1, 0);
        chk("bnd_ch2_full", h2, 25);
        chk("bnd_ch3_off", h3, 0);
        chk("bnd_ch0_off", h0, 0);
        chk("bnd_en", int'(cio_pwm_en_o), 6);

        // Prescaler
        cyc(1'b1, 4'd0, 16'd0); cyc(1'b1, 4'd1, 16'd3); cyc(1'b1, 4'd2, 16'd4);
        cyc(1'b1, 4'd4, 16'd2); cyc(1'b1, 4'd0, 16'd1);
        repeat (3) cyc(1'b0, 4'd2, 16'h0);
        window(60, h0, h1, h2, h3, w, r0);
        chk("pre_high", h0, 24);
        chk("pre_wraps", w, 3);
        chk("pre_run", r0, 8);

        // Polarity
        cyc(1'b1, 4'd0, 16'd0); cyc(1'b1, 4'd1, 16'd0); cyc(1'b1, 4'd2, 16'd9);
        cyc(1'b1, 4'd4, 16'd3); cyc(1'b1, 4'd3, 16'd1); cyc(1'b1, 4'd0, 16'd1);
        repeat (3) cyc(1'b0, 4'd2, 16'h0);
        window(30, h0, h1, h2, h3, w, r0);
`ifdef PWM_POLARITY_EN
        chk("pol_high", h0, 21);
`else
        chk("pol_high", h0, 9);
`endif

        // Async reset while output is high
        k = 0;
        do begin
            cyc(1'b0, 4'd2, 16'h0);
            k++;
        end while (!cio_pwm_o[0] && k < 40);
        chk("pre_rst_high", int'(cio_pwm_o[0]), 1);
        #2;
        rst_ni = 1'b0;
        reg_addr_i = 4'd2;
        #1;
        chk("arst_pwm", int'(cio_pwm_o), 0);
        chk("arst_en", int'(cio_pwm_en_o), 0);
        chk("arst_wrap", int'(wrap_o), 0);
        chk("arst_period", int'(reg_rdata_o), 255);
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Randomized writes against the reference model
        for (int n = 0; n < 3000; n++) begin
            we = ($urandom_range(0, 5) == 0);
            a  = 4'($urandom_range(0, 15));
            case (a)
                4'd0:    wd = 16'($urandom_range(0, 15)) | (16'($urandom) & 16'hFFF0);
                4'd1:    wd = 16'($urandom_range(0, 3));
                4'd2:    wd = 16'($urandom_range(0, 12));
                4'd3:    wd = 16'($urandom);
                default: wd = 16'($urandom_range(0, 14));
            endcase
            cyc(we, a, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
